// File: rtl/alu_mul_seq_pkg.sv
// Shared encodings for ALU-driven sequencers: FSM states and the ALU control words.
// The control word layout is {zx, nx, zy, ny, f, no}.
package alu_mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FLAG = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [5:0] ALU_CTL_ZERO   = 6'b101010;
    localparam logic [5:0] ALU_CTL_PASS_X = 6'b001100;

    // x + y, with y forced to zero when zy is set.
    function automatic logic [5:0] alu_ctl_add(input logic zy);
        return {2'b00, zy, 3'b010};
    endfunction

endpackage

// File: rtl/alu16.sv
// Shared 16-bit ALU living beside the sequencers in the parent.
// Purely combinational: optional zero/negate on each operand, add or AND, optional output negate.
module alu16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [5:0]  ctl,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x1, x2, y1, y2, f_out;

    always_comb begin
        x1    = ctl[5] ? 16'h0000 : x;
        x2    = ctl[4] ? ~x1 : x1;
        y1    = ctl[3] ? 16'h0000 : y;
        y2    = ctl[2] ? ~y1 : y1;
        f_out = ctl[1] ? (x2 + y2) : (x2 & y2);
        out   = ctl[0] ? ~f_out : f_out;
        zr    = (out == 16'h0000);
        ng    = out[15];
    end
endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 -> low-16 multiplier that borrows the external ALU one step per clock.
// The product and its ALU zero/negative flags are returned on a valid/ready response port.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_prod,
    output logic        rsp_zr,
    output logic        rsp_ng,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng
);
    state_e      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [4:0]  step_q, step_d;
    logic [15:0] prod_q, prod_d;
    logic        zr_q, zr_d;
    logic        ng_q, ng_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            step_q   <= '0;
            prod_q   <= '0;
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            step_q   <= step_d;
            prod_q   <= prod_d;
            zr_q     <= zr_d;
            ng_q     <= ng_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        step_d   = step_q;
        prod_d   = prod_q;
        zr_d     = zr_q;
        ng_d     = ng_q;
        alu_x    = 16'h0000;
        alu_y    = 16'h0000;
        alu_ctl  = ALU_CTL_ZERO;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    acc_d    = 16'h0000;
                    mcand_d  = req_a;
                    mplier_d = req_b;
                    step_d   = 5'd0;
                    state_d  = ST_ADD;
                end
            end
            ST_ADD: begin
                // A clear multiplier bit zeroes y, so the step still runs but adds nothing.
                alu_x    = acc_q;
                alu_y    = mcand_q;
                alu_ctl  = alu_ctl_add(~mplier_q[0]);
                acc_d    = alu_out;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[15:1]};
                step_d   = step_q + 5'd1;
                if (step_q == 5'd15 || (EARLY_EXIT && mplier_q[15:1] == 15'd0)) begin
                    state_d = ST_FLAG;
                end
            end
            ST_FLAG: begin
                // Flags are taken from the ALU, never recomputed here.
                alu_x   = acc_q;
                alu_ctl = ALU_CTL_PASS_X;
                prod_d  = alu_out;
                zr_d    = alu_zr;
                ng_d    = alu_ng;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_prod  = prod_q;
    assign rsp_zr    = zr_q;
    assign rsp_ng    = ng_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench: two multipliers (EARLY_EXIT=0 and 1), each wired to its own ALU,
// with expected products/latencies queued at issue and checked by a negedge monitor.
module tb_alu_mul_seq;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        logic        zr;
        logic        ng;
        int          t0;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [15:0] req_a     [2];
    logic [15:0] req_b     [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_prod  [2];
    logic        rsp_zr    [2];
    logic        rsp_ng    [2];
    logic [15:0] alu_x     [2];
    logic [15:0] alu_y     [2];
    logic [5:0]  alu_ctl   [2];
    logic [15:0] alu_out   [2];
    logic        alu_zr    [2];
    logic        alu_ng    [2];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb [2][$];
    bit   seen [2];
    bit   rand_bp = 1'b0;
    logic rdy_lvl = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mul_seq #(.EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_prod(rsp_prod[0]), .rsp_zr(rsp_zr[0]), .rsp_ng(rsp_ng[0]),
        .alu_x(alu_x[0]), .alu_y(alu_y[0]), .alu_ctl(alu_ctl[0]),
        .alu_out(alu_out[0]), .alu_zr(alu_zr[0]), .alu_ng(alu_ng[0])
    );
    alu16 u_alu0 (.x(alu_x[0]), .y(alu_y[0]), .ctl(alu_ctl[0]),
                  .out(alu_out[0]), .zr(alu_zr[0]), .ng(alu_ng[0]));

    alu_mul_seq #(.EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_prod(rsp_prod[1]), .rsp_zr(rsp_zr[1]), .rsp_ng(rsp_ng[1]),
        .alu_x(alu_x[1]), .alu_y(alu_y[1]), .alu_ctl(alu_ctl[1]),
        .alu_out(alu_out[1]), .alu_zr(alu_zr[1]), .alu_ng(alu_ng[1])
    );
    alu16 u_alu1 (.x(alu_x[1]), .y(alu_y[1]), .ctl(alu_ctl[1]),
                  .out(alu_out[1]), .zr(alu_zr[1]), .ng(alu_ng[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modular multiply; latency from the position of b's top set bit.
    function automatic exp_t model(input int d, input logic [15:0] a, input logic [15:0] b, input int t0);
        exp_t e;
        int   k;
        int   full;
        full   = int'(a) * int'(b);
        e.a    = a;
        e.b    = b;
        e.prod = full[15:0];
        e.zr   = (e.prod == 16'h0000);
        e.ng   = e.prod[15];
        e.t0   = t0;
        k = 1;
        for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
        e.lat  = (d == 0) ? 17 : k + 1;
        return e;
    endfunction

    // Backpressure driver, updated just after each rising edge.
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++)
            rsp_ready[d] = rand_bp ? ($urandom_range(0, 3) != 0) : rdy_lvl;
    end

    task automatic mon_step(input int d);
        exp_t e;
        if (rst_n && rsp_valid[d]) begin
            if (sb[d].size() == 0) begin
                chk($sformatf("unexpected_rsp%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
            end else begin
                e = sb[d][0];
                chk($sformatf("prod%0d", d), {16'd0, rsp_prod[d]}, {16'd0, e.prod});
                chk($sformatf("zr%0d", d), {31'd0, rsp_zr[d]}, {31'd0, e.zr});
                chk($sformatf("ng%0d", d), {31'd0, rsp_ng[d]}, {31'd0, e.ng});
                chk($sformatf("req_ready_in_resp%0d", d), {31'd0, req_ready[d]}, 32'd0);
                if (!seen[d]) begin
                    chk($sformatf("latency%0d", d), cyc - e.t0, e.lat);
                    seen[d] = 1'b1;
                end
                if (rsp_ready[d]) begin
                    $display("dut%0d a=%h b=%h prod=%h zr=%0d ng=%0d exp=%h lat=%0d",
                             d, e.a, e.b, rsp_prod[d], rsp_zr[d], rsp_ng[d], e.prod, e.lat);
                    void'(sb[d].pop_front());
                    seen[d] = 1'b0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    // Waits for req_ready, lets one edge accept, and queues the expected response.
    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b, input bit push);
        int w = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_a[d] = a;
        req_b[d] = b;
        while (!req_ready[d] && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            chk($sformatf("req_ready_timeout%0d", d), 32'd0, 32'd1);
            req_valid[d] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (push) sb[d].push_back(model(d, a, b, cyc));
            req_valid[d] = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          w;
        logic [15:0] ra, rb;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_a[d] = 16'h0;
            req_b[d] = 16'h0;
            rsp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
            chk("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
            chk("rst_rsp_prod", {16'd0, rsp_prod[d]}, 32'd0);
            chk("rst_flags", {30'd0, rsp_zr[d], rsp_ng[d]}, 32'd0);
            chk("rst_alu_ctl", {26'd0, alu_ctl[d]}, 32'h2A);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the fifth ADD step abandons the operation.
        issue(0, 16'h1234, 16'hFFFF, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);

        // Directed corner values on both variants.
        issue(0, 16'd3, 16'd5, 1'b1);
        for (int d = 0; d < 2; d++) begin
            issue(d, 16'h00FF, 16'h0101, 1'b1);
            issue(d, 16'h8000, 16'h0002, 1'b1);
            issue(d, 16'hFFFF, 16'hFFFF, 1'b1);
            issue(d, 16'd7, 16'd1, 1'b1);
            issue(d, 16'h1234, 16'h0000, 1'b1);
            issue(d, 16'hABCD, 16'h8000, 1'b1);
        end
        drain();

        // Held response: stable outputs, requests ignored, then back-to-back acceptance.
        rdy_lvl = 1'b0;
        @(posedge clk);
        issue(1, 16'h0123, 16'h0045, 1'b1);
        w = 0;
        while (!rsp_valid[1] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("stall_wait_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            req_valid[1] = 1'b1;
            req_a[1] = 16'hDEAD;
            req_b[1] = 16'hBEEF;
            chk("stall_req_ready", {31'd0, req_ready[1]}, 32'd0);
            @(negedge clk);
        end
        req_a[1] = 16'h0321;
        req_b[1] = 16'h0007;
        rdy_lvl = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_ready", {31'd0, req_ready[1]}, 32'd1);
        @(posedge clk);
        #1;
        chk("b2b_accepted", {31'd0, req_ready[1]}, 32'd0);
        sb[1].push_back(model(1, 16'h0321, 16'h0007, cyc));
        req_valid[1] = 1'b0;
        drain();

        // Randomized traffic under random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < 2; d++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 15);
                issue(d, ra, rb, 1'b1);
            end
        end
        drain();
        rand_bp = 1'b0;
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
